io_port_device: RTL and testbench

IO_PORT_DEVICE -- requirements
Module: io_port_device

---
 rtl/io_port_pkg.sv | 16 +
 rtl/io_port_device_if.sv | 32 +++
 rtl/io_sync_fifo.sv | 56 +++++
 rtl/io_port_device.sv | 71 +++++++
 tb/tb_io_port_device.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_port_pkg.sv
// Shared types and constants for the CPU/host I/O port device.
// Build option IO_PORT_ERR_CNT_EN enables the stall/error event counter.
package io_port_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam int unsigned ERR_CNT_W     = 8;

   typedef logic [ERR_CNT_W-1:0] err_cnt_t;

   function automatic err_cnt_t sat_inc(input err_cnt_t v);
      return (v == '1) ? v : err_cnt_t'(v + 1'b1);
   endfunction

endpackage

// File: rtl/io_port_device_if.sv
// CPU in/out strobes and host-side valid/ready queues of the I/O port device.
// Master is the CPU/host side driving strobes; slave is the device.
interface io_port_device_if;
   import io_port_pkg::*;

   word_t    OutPort_output;
   logic     out_wr;
   word_t    inPort_input;
   logic     in_rd;
   logic     in_avail;
   logic     cpu_stall;
   word_t    host_in_data;
   logic     host_in_valid;
   logic     host_in_ready;
   word_t    host_out_data;
   logic     host_out_valid;
   logic     host_out_ready;
   err_cnt_t err_count;

   modport master (
      output OutPort_output, out_wr, in_rd, host_in_data, host_in_valid, host_out_ready,
      input  inPort_input, in_avail, cpu_stall, host_in_ready, host_out_data,
             host_out_valid, err_count
   );

   modport slave (
      input  OutPort_output, out_wr, in_rd, host_in_data, host_in_valid, host_out_ready,
      output inPort_input, in_avail, cpu_stall, host_in_ready, host_out_data,
             host_out_valid, err_count
   );

endinterface

// File: rtl/io_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
// Head word reads as zero while empty; push when full and pop when empty are ignored.
module io_sync_fifo
   import io_port_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  word_t                        push_data,
   input  logic                         pop,
   output word_t                        pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   word_t          mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_port_device.sv
// CPU in/out port bridge: host->CPU input FIFO and CPU->host output FIFO with stall.
// Define IO_PORT_ERR_CNT_EN to count stall cycles in err_count (saturating).
module io_port_device
   import io_port_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic              RAM_Clock,
   input  logic              Reset,
   io_port_device_if.slave   bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic          in_full;
   logic          in_empty;
   logic [CW-1:0] in_count;
   logic          out_full;
   logic          out_empty;
   logic [CW-1:0] out_count;
   logic          stall;

   io_sync_fifo #(.DEPTH(DEPTH)) u_in_fifo (
      .clk       (RAM_Clock),
      .rst       (Reset),
      .push      (bus.host_in_valid),
      .push_data (bus.host_in_data),
      .pop       (bus.in_rd),
      .pop_data  (bus.inPort_input),
      .full      (in_full),
      .empty     (in_empty),
      .count     (in_count)
   );

   io_sync_fifo #(.DEPTH(DEPTH)) u_out_fifo (
      .clk       (RAM_Clock),
      .rst       (Reset),
      .push      (bus.out_wr),
      .push_data (bus.OutPort_output),
      .pop       (bus.host_out_ready),
      .pop_data  (bus.host_out_data),
      .full      (out_full),
      .empty     (out_empty),
      .count     (out_count)
   );

   // Reset suppresses stall so the CPU is never held during the reset cycle.
   assign stall             = ~Reset & ((bus.in_rd & in_empty) | (bus.out_wr & out_full));
   assign bus.cpu_stall     = stall;
   assign bus.in_avail      = ~in_empty;
   assign bus.host_in_ready = ~in_full;
   assign bus.host_out_valid = ~out_empty;

   occupancy_in_range: assert property (@(posedge RAM_Clock) disable iff (Reset)
      (in_count <= CNT_MAX) && (out_count <= CNT_MAX));

`ifdef IO_PORT_ERR_CNT_EN
   err_cnt_t err_q;

   always_ff @(posedge RAM_Clock) begin
      if (Reset)      err_q <= '0;
      else if (stall) err_q <= sat_inc(err_q);
   end

   assign bus.err_count = err_q;
`else
   assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_io_port_device.sv
// Scoreboard bench for io_port_device: directed stimulus queues expected words,
// a negedge monitor compares every word the DUT hands out. Honours IO_PORT_ERR_CNT_EN.
module tb_io_port_device;
   import io_port_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   io_port_device_if bus ();

   io_port_device #(.DEPTH(DEPTH)) dut (
      .RAM_Clock (clk),
      .Reset     (rst),
      .bus       (bus)
   );

   int          total = 0;
   int          bad = 0;
   int unsigned stall_cycles = 0;
   word_t       exp_in[$];
   word_t       exp_out[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] exp_err();
`ifdef IO_PORT_ERR_CNT_EN
      return (stall_cycles > 255) ? 32'd255 : 32'(stall_cycles);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.host_in_valid = 1'b0;
      bus.in_rd         = 1'b0;
      bus.out_wr        = 1'b0;
   endtask

   // Monitor: every consumed word must match the next expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.in_rd && bus.in_avail) begin
            if (exp_in.size() == 0) begin
               total++; bad++;
               $display("FAIL in_word_unexpected: actual=%h required=none", bus.inPort_input);
            end else check("in_word", bus.inPort_input, exp_in.pop_front());
         end
         if (bus.host_out_valid && bus.host_out_ready) begin
            if (exp_out.size() == 0) begin
               total++; bad++;
               $display("FAIL out_word_unexpected: actual=%h required=none", bus.host_out_data);
            end else check("out_word", bus.host_out_data, exp_out.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bus.OutPort_output = '0;
      bus.host_in_data   = '0;
      bus.host_out_ready = 1'b0;
      drive_idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_avail", bus.in_avail, 0);
      check("rst_in_data", bus.inPort_input, 0);
      check("rst_in_ready", bus.host_in_ready, 1);
      check("rst_out_valid", bus.host_out_valid, 0);
      check("rst_out_data", bus.host_out_data, 0);
      check("rst_err", bus.err_count, 0);
      check("rst_stall", bus.cpu_stall, 0);

      // Host pushes 56, 34; CPU reads both
      tick();
      bus.host_in_valid = 1'b1; bus.host_in_data = 32'h56; exp_in.push_back(32'h56);
      @(negedge clk);
      check("in_ready_empty", bus.host_in_ready, 1);
      check("avail_same_cycle", bus.in_avail, 0);
      tick();
      bus.host_in_data = 32'h34; exp_in.push_back(32'h34);
      @(negedge clk);
      check("avail_after_push", bus.in_avail, 1);
      check("head_56", bus.inPort_input, 32'h56);
      tick();
      bus.host_in_valid = 1'b0; bus.in_rd = 1'b1;
      @(negedge clk);
      check("rd_no_stall", bus.cpu_stall, 0);
      tick();
      bus.in_rd = 1'b0;
      @(negedge clk);
      check("head_34", bus.inPort_input, 32'h34);
      tick();
      bus.in_rd = 1'b1;
      @(negedge clk);
      tick();
      bus.in_rd = 1'b0;
      @(negedge clk);
      check("drained_avail", bus.in_avail, 0);
      check("drained_data", bus.inPort_input, 0);

      // Read on empty input FIFO stalls
      tick();
      bus.in_rd = 1'b1;
      @(negedge clk);
      check("empty_rd_stall", bus.cpu_stall, 1);
      check("empty_rd_data", bus.inPort_input, 0);
      stall_cycles++;
      tick();
      bus.in_rd = 1'b0;
      @(negedge clk);
      check("err_after_underflow", bus.err_count, exp_err());
      check("stall_clear", bus.cpu_stall, 0);

      // Push to empty with same-cycle read: read stalls, word arrives next cycle
      tick();
      bus.host_in_valid = 1'b1; bus.host_in_data = 32'hAA; bus.in_rd = 1'b1;
      exp_in.push_back(32'hAA);
      @(negedge clk);
      check("push_rd_same_stall", bus.cpu_stall, 1);
      stall_cycles++;
      tick();
      bus.host_in_valid = 1'b0;
      @(negedge clk);
      check("push_rd_next_stall", bus.cpu_stall, 0);
      check("push_rd_next_avail", bus.in_avail, 1);
      tick();
      bus.in_rd = 1'b0;
      @(negedge clk);
      check("push_rd_avail_end", bus.in_avail, 0);
      check("err_two", bus.err_count, exp_err());

      // Five CPU writes into a depth-4 output FIFO with host not ready
      bus.host_out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         bus.out_wr = 1'b1; bus.OutPort_output = 32'(i);
         @(negedge clk);
         check("out_full_stall", bus.cpu_stall, (i == 5) ? 1 : 0);
         if (i < 5) exp_out.push_back(32'(i));
         else stall_cycles++;
      end
      tick();
      bus.out_wr = 1'b0;
      @(negedge clk);
      check("out_valid_full", bus.host_out_valid, 1);
      check("out_head_1", bus.host_out_data, 32'h1);
      check("out_in_ready", bus.host_in_ready, 1);
      tick();
      bus.host_out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         tick();
      end
      bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("out_drained", bus.host_out_valid, 0);
      check("err_three", bus.err_count, exp_err());

      // Half occupancy: simultaneous write and host pop
      tick(); bus.out_wr = 1'b1; bus.OutPort_output = 32'h10; exp_out.push_back(32'h10);
      tick(); bus.OutPort_output = 32'h11; exp_out.push_back(32'h11);
      tick(); bus.OutPort_output = 32'h12; exp_out.push_back(32'h12); bus.host_out_ready = 1'b1;
      @(negedge clk);
      check("half_out_stall", bus.cpu_stall, 0);
      check("half_out_head", bus.host_out_data, 32'h10);
      tick();
      bus.out_wr = 1'b0; bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("half_out_next", bus.host_out_data, 32'h11);
      tick();
      bus.host_out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         tick();
      end
      bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("half_out_empty", bus.host_out_valid, 0);

      tick(); bus.host_in_valid = 1'b1; bus.host_in_data = 32'h20; exp_in.push_back(32'h20);
      tick(); bus.host_in_data = 32'h21; exp_in.push_back(32'h21);
      tick(); bus.host_in_data = 32'h22; exp_in.push_back(32'h22); bus.in_rd = 1'b1;
      @(negedge clk);
      check("half_in_stall", bus.cpu_stall, 0);
      check("half_in_head", bus.inPort_input, 32'h20);
      tick();
      drive_idle();
      @(negedge clk);
      check("half_in_next", bus.inPort_input, 32'h21);
      tick();
      bus.in_rd = 1'b1;
      repeat (2) begin
         @(negedge clk);
         tick();
      end
      bus.in_rd = 1'b0;
      @(negedge clk);
      check("half_in_empty", bus.in_avail, 0);

      // Reset with three words queued each way
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.host_in_valid = 1'b1; bus.host_in_data = 32'h100 + 32'(i);
         bus.out_wr = 1'b1; bus.OutPort_output = 32'h200 + 32'(i);
      end
      tick();
      drive_idle();
      @(negedge clk);
      check("pre_rst_in_head", bus.inPort_input, 32'h100);
      check("pre_rst_out_head", bus.host_out_data, 32'h200);
      tick();
      rst = 1'b1;
      bus.in_rd = 1'b1; bus.out_wr = 1'b1; bus.host_in_valid = 1'b1; bus.host_out_ready = 1'b1;
      @(negedge clk);
      check("rst_cycle_stall_a", bus.cpu_stall, 0);
      exp_in.delete();
      exp_out.delete();
      stall_cycles = 0;
      tick();
      @(negedge clk);
      check("rst_cycle_stall_b", bus.cpu_stall, 0);
      tick();
      rst = 1'b0;
      drive_idle();
      bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("mid_rst_in_avail", bus.in_avail, 0);
      check("mid_rst_in_data", bus.inPort_input, 0);
      check("mid_rst_in_ready", bus.host_in_ready, 1);
      check("mid_rst_out_valid", bus.host_out_valid, 0);
      check("mid_rst_out_data", bus.host_out_data, 0);
      check("mid_rst_err", bus.err_count, 0);
      tick();
      bus.host_in_valid = 1'b1; bus.host_in_data = 32'h300; exp_in.push_back(32'h300);
      bus.out_wr = 1'b1; bus.OutPort_output = 32'h400; exp_out.push_back(32'h400);
      tick();
      drive_idle();
      @(negedge clk);
      check("fresh_in_head", bus.inPort_input, 32'h300);
      check("fresh_out_head", bus.host_out_data, 32'h400);
      tick();
      bus.in_rd = 1'b1; bus.host_out_ready = 1'b1;
      @(negedge clk);
      tick();
      drive_idle();
      bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("fresh_in_empty", bus.in_avail, 0);
      check("fresh_out_empty", bus.host_out_valid, 0);

      // Streaming past 2*DEPTH words in both directions
      bus.host_out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         bus.host_in_valid = 1'b1; bus.host_in_data = 32'hA000_0000 + 32'(k);
         bus.out_wr = 1'b1; bus.OutPort_output = 32'hB000_0000 + 32'(k);
         bus.in_rd = (k != 0);
         exp_in.push_back(32'hA000_0000 + 32'(k));
         exp_out.push_back(32'hB000_0000 + 32'(k));
         @(negedge clk);
         check("stream_stall", bus.cpu_stall, 0);
      end
      tick();
      bus.host_in_valid = 1'b0; bus.out_wr = 1'b0; bus.in_rd = 1'b1;
      @(negedge clk);
      tick();
      drive_idle();
      bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("stream_in_empty", bus.in_avail, 0);
      check("stream_out_empty", bus.host_out_valid, 0);
      check("stream_err", bus.err_count, exp_err());

      // Overfill after wrap: three refused writes
      for (int i = 0; i < 7; i++) begin
         tick();
         bus.out_wr = 1'b1; bus.OutPort_output = 32'hC0 + 32'(i);
         @(negedge clk);
         check("wrap_full_stall", bus.cpu_stall, (i >= 4) ? 1 : 0);
         if (i < 4) exp_out.push_back(32'hC0 + 32'(i));
         else stall_cycles++;
      end
      tick();
      bus.out_wr = 1'b0;
      @(negedge clk);
      check("wrap_err", bus.err_count, exp_err());
      tick();
      bus.host_out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         tick();
      end
      bus.host_out_ready = 1'b0;
      @(negedge clk);
      check("wrap_out_empty", bus.host_out_valid, 0);
      check("in_queue_left", 32'(exp_in.size()), 0);
      check("out_queue_left", 32'(exp_out.size()), 0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
